// File: rtl/spi_cfg_arbiter.sv
// Round-robin arbiter sharing one spi_master among NUM_CH config clients; SPI command issues 2 cycles after the request.
// No backpressure: a request to a channel that is already busy is dropped and flagged on o_err the next cycle.
module spi_cfg_arbiter #(
    parameter int NUM_CH          = 2,
    parameter int MOSI_DATA_WIDTH = 24,
    parameter int MISO_DATA_WIDTH = 8,
    parameter int BUSY_TIMEOUT    = 255
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [NUM_CH-1:0]                 i_wr_cmd,
    input  logic [NUM_CH-1:0]                 i_rd_cmd,
    input  logic [NUM_CH*MOSI_DATA_WIDTH-1:0] i_wr_data,
    output logic [NUM_CH-1:0]                 o_busy,
    output logic [NUM_CH-1:0]                 o_done,
    output logic [NUM_CH-1:0]                 o_err,
    output logic [MISO_DATA_WIDTH-1:0]        o_rd_data,
    output logic                              o_spi_wr_cmd,
    output logic                              o_spi_rd_cmd,
    output logic [MOSI_DATA_WIDTH-1:0]        o_spi_wr_data,
    input  logic                              i_spi_busy,
    input  logic [MISO_DATA_WIDTH-1:0]        i_spi_rd_data,
    input  logic                              i_spi_ncs,
    output logic [NUM_CH-1:0]                 o_cs_n
);

    localparam int GW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int CW = $clog2(BUSY_TIMEOUT + 1);
    localparam logic [CW-1:0] TO_LAST = CW'(BUSY_TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE} state_t;

    typedef struct packed {
        logic                       rd;
        logic [MOSI_DATA_WIDTH-1:0] word;
    } req_t;

    state_t              state;
    state_t              state_nxt;
    logic [NUM_CH-1:0]   pending;
    logic [NUM_CH-1:0]   to_err;
    logic [NUM_CH-1:0]   ovr;
    logic [NUM_CH-1:0]   gnt_oh;
    req_t                req_q [NUM_CH];
    logic [GW-1:0]       grant;
    logic [GW-1:0]       rr_pick;
    logic                gnt_rd;
    logic [CW-1:0]       to_cnt;
    logic                take_grant;
    logic                finish_ok;
    logic                finish_to;

    assign gnt_oh = NUM_CH'(1) << grant;
    // Busy spans the completion pulse so a client never sees a gap before o_done/o_err.
    assign o_busy = pending | o_done | to_err;
    assign ovr    = (i_wr_cmd | i_rd_cmd) & o_busy;
    assign o_cs_n = (state != IDLE) ? (~gnt_oh | {NUM_CH{i_spi_ncs}}) : '1;

    always_comb begin
        logic [GW-1:0] cand;
        logic          found;
        rr_pick = grant;
        cand    = grant;
        found   = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            cand = (cand == GW'(NUM_CH - 1)) ? '0 : cand + GW'(1);
            if (!found && pending[cand]) begin
                rr_pick = cand;
                found   = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        take_grant   = 1'b0;
        finish_ok    = 1'b0;
        finish_to    = 1'b0;
        o_spi_wr_cmd = 1'b0;
        o_spi_rd_cmd = 1'b0;
        case (state)
            IDLE: begin
                if (|pending) begin
                    take_grant = 1'b1;
                    state_nxt  = ISSUE;
                end
            end
            ISSUE: begin
                o_spi_rd_cmd = gnt_rd;
                o_spi_wr_cmd = !gnt_rd;
                state_nxt    = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (i_spi_busy) begin
                    state_nxt = WAIT_DONE;
                end else if (to_cnt >= TO_LAST) begin
                    finish_to = 1'b1;
                    state_nxt = IDLE;
                end
            end
            WAIT_DONE: begin
                if (!i_spi_busy) begin
                    finish_ok = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // to_cnt counts cycles since ISSUE, so the timeout fires BUSY_TIMEOUT cycles after the command.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grant         <= GW'(NUM_CH - 1);
            gnt_rd        <= 1'b0;
            to_cnt        <= '0;
            o_spi_wr_data <= '0;
            o_rd_data     <= '0;
            o_done        <= '0;
            o_err         <= '0;
            to_err        <= '0;
        end else begin
            if (take_grant) begin
                grant         <= rr_pick;
                gnt_rd        <= req_q[rr_pick].rd;
                o_spi_wr_data <= req_q[rr_pick].word;
            end
            to_cnt <= (state == ISSUE || state == WAIT_BUSY) ? to_cnt + CW'(1) : '0;
            if (finish_ok) begin
                o_rd_data <= i_spi_rd_data;
            end
            o_done <= finish_ok ? gnt_oh : '0;
            to_err <= finish_to ? gnt_oh : '0;
            o_err  <= (finish_to ? gnt_oh : '0) | ovr;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending <= '0;
            for (int k = 0; k < NUM_CH; k++) begin
                req_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < NUM_CH; k++) begin
                if ((i_wr_cmd[k] || i_rd_cmd[k]) && !o_busy[k]) begin
                    pending[k]    <= 1'b1;
                    req_q[k].rd   <= i_rd_cmd[k];
                    req_q[k].word <= i_wr_data[k*MOSI_DATA_WIDTH +: MOSI_DATA_WIDTH];
                end else if ((finish_ok || finish_to) && gnt_oh[k]) begin
                    pending[k] <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_spi_cfg_arbiter.sv
// Scoreboard bench for spi_cfg_arbiter with a behavioural spi_master model.
module tb_spi_cfg_arbiter;

    localparam int NCH = 2;
    localparam int MW  = 24;
    localparam int DW  = 8;
    localparam int TO  = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic [NCH-1:0]    wr_cmd;
    logic [NCH-1:0]    rd_cmd;
    logic [NCH*MW-1:0] wr_data;
    logic [NCH-1:0]    o_busy;
    logic [NCH-1:0]    o_done;
    logic [NCH-1:0]    o_err;
    logic [DW-1:0]     o_rd_data;
    logic              o_spi_wr_cmd;
    logic              o_spi_rd_cmd;
    logic [MW-1:0]     o_spi_wr_data;
    logic              spi_busy    = 1'b0;
    logic [DW-1:0]     spi_rd_data = '0;
    logic              spi_ncs     = 1'b1;
    logic [NCH-1:0]    o_cs_n;

    always #5 clk = ~clk;

    spi_cfg_arbiter #(
        .NUM_CH(NCH), .MOSI_DATA_WIDTH(MW), .MISO_DATA_WIDTH(DW), .BUSY_TIMEOUT(TO)
    ) dut (
        .clk(clk), .rst(rst),
        .i_wr_cmd(wr_cmd), .i_rd_cmd(rd_cmd), .i_wr_data(wr_data),
        .o_busy(o_busy), .o_done(o_done), .o_err(o_err), .o_rd_data(o_rd_data),
        .o_spi_wr_cmd(o_spi_wr_cmd), .o_spi_rd_cmd(o_spi_rd_cmd), .o_spi_wr_data(o_spi_wr_data),
        .i_spi_busy(spi_busy), .i_spi_rd_data(spi_rd_data), .i_spi_ncs(spi_ncs),
        .o_cs_n(o_cs_n)
    );

    typedef struct {
        int           ch;
        logic         rd;
        logic [MW-1:0] word;
        logic [DW-1:0] rdat;
        logic         is_to;
    } exp_t;

    exp_t exp_q[$];
    exp_t e;

    int n_vec  = 0;
    int n_miss = 0;
    int cyc    = 0;
    int cmd_cnt = 0;
    int ovr_cnt = 0;
    int done_cnt [NCH];
    int issue_cyc = 0;
    int last_done_cyc = -1000;
    int last_gap = 0;
    int cur_ch = 0;
    bit inflight = 0;

    int         m_lat = 4;
    int         m_len = 30;
    bit         m_never = 0;
    logic [DW-1:0] m_rd_val = '0;
    int         m_phase = 0;
    int         m_cnt = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // spi_master model: busy rises m_lat cycles after a command and stays up m_len cycles.
    always @(posedge clk) begin
        #1;
        if (rst) begin
            m_phase  = 0;
            spi_busy = 1'b0;
            spi_ncs  = 1'b1;
        end else begin
            case (m_phase)
                0: if ((o_spi_wr_cmd || o_spi_rd_cmd) && !m_never) begin
                    m_phase = 1;
                    m_cnt   = m_lat;
                end
                1: begin
                    m_cnt--;
                    if (m_cnt <= 0) begin
                        spi_busy = 1'b1;
                        spi_ncs  = 1'b0;
                        m_cnt    = m_len;
                        m_phase  = 2;
                    end
                end
                2: begin
                    m_cnt--;
                    if (m_cnt <= 0) begin
                        spi_busy    = 1'b0;
                        spi_ncs     = 1'b1;
                        spi_rd_data = m_rd_val;
                        m_phase     = 0;
                    end
                end
                default: m_phase = 0;
            endcase
        end
    end

    always @(negedge clk) begin
        logic [NCH-1:0] exp_cs;
        if (rst) begin
            inflight = 0;
        end else begin
            if (o_spi_wr_cmd || o_spi_rd_cmd) begin
                cmd_cnt++;
                if (exp_q.size() == 0) begin
                    chk("issue_unexpected", 32'(1), 32'(0));
                end else begin
                    chk("issue_rd", 32'(o_spi_rd_cmd), 32'(exp_q[0].rd));
                    chk("issue_data", 32'(o_spi_wr_data), 32'(exp_q[0].word));
                    inflight  = 1;
                    cur_ch    = exp_q[0].ch;
                    issue_cyc = cyc;
                    last_gap  = cyc - last_done_cyc;
                end
            end
            if (o_done != '0) begin
                for (int k = 0; k < NCH; k++) done_cnt[k] += int'(o_done[k]);
                if (exp_q.size() == 0 || !inflight) begin
                    chk("done_unexpected", 32'(o_done), 32'(0));
                end else begin
                    e = exp_q.pop_front();
                    chk("done_ch", 32'(o_done), 32'(1) << e.ch);
                    chk("done_kind", 32'(0), 32'(e.is_to));
                    chk("done_rd_data", 32'(o_rd_data), 32'(e.rdat));
                    chk("done_busy_held", 32'(o_busy[e.ch]), 32'(1));
                    inflight      = 0;
                    last_done_cyc = cyc;
                end
            end
            if (o_err != '0) begin
                if (inflight && exp_q.size() > 0 && exp_q[0].is_to) begin
                    e = exp_q.pop_front();
                    chk("to_ch", 32'(o_err), 32'(1) << e.ch);
                    chk("to_latency", 32'(cyc - issue_cyc), 32'(TO));
                    chk("to_busy_held", 32'(o_busy[e.ch]), 32'(1));
                    inflight      = 0;
                    last_done_cyc = cyc;
                end else begin
                    ovr_cnt += $countones(o_err);
                end
            end
            exp_cs = '1;
            if (inflight) exp_cs[cur_ch] = spi_ncs;
            chk("cs_n", 32'(o_cs_n), 32'(exp_cs));
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input int ch, input logic rd, input logic [MW-1:0] word,
                        input logic [DW-1:0] rdat, input logic is_to);
        exp_t x;
        x.ch = ch; x.rd = rd; x.word = word; x.rdat = rdat; x.is_to = is_to;
        exp_q.push_back(x);
    endtask

    task automatic req(input logic [NCH-1:0] wr, input logic [NCH-1:0] rd, input logic [NCH*MW-1:0] data);
        wr_cmd  = wr;
        rd_cmd  = rd;
        wr_data = data;
        tick(1);
        wr_cmd = '0;
        rd_cmd = '0;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        bit ok;
        ok = 0;
        for (int i = 0; i < budget && !ok; i++) begin
            tick(1);
            if (exp_q.size() == 0 && o_busy == '0 && !spi_busy) ok = 1;
        end
        chk(tag, 32'(ok), 32'(1));
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_busy"}, 32'(o_busy), 32'(0));
        chk({tag, "_done"}, 32'(o_done), 32'(0));
        chk({tag, "_err"}, 32'(o_err), 32'(0));
        chk({tag, "_cs_n"}, 32'(o_cs_n), 32'(2'b11));
        chk({tag, "_spi_cmds"}, 32'({o_spi_wr_cmd, o_spi_rd_cmd}), 32'(0));
        chk({tag, "_wr_data"}, 32'(o_spi_wr_data), 32'(0));
        chk({tag, "_rd_data"}, 32'(o_rd_data), 32'(0));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int c0, d0, d1, o0;
        bit seen;
        for (int k = 0; k < NCH; k++) done_cnt[k] = 0;
        rst = 1'b1; wr_cmd = '0; rd_cmd = '0; wr_data = '0;
        tick(2);
        wr_cmd  = 2'b11;
        wr_data = {24'h111111, 24'h222222};
        #1;
        chk_reset_vals("reset");
        tick(1);
        wr_cmd = '0;
        rst = 1'b0;
        tick(3);
        chk("reset_req_ignored", 32'(o_busy), 32'(0));
        chk("reset_no_cmd", 32'(cmd_cnt), 32'(0));

        // single write on ch1
        m_lat = 4; m_len = 30; m_rd_val = 8'hC3;
        c0 = cmd_cnt; d1 = done_cnt[1];
        push(1, 1'b0, 24'h001C02, 8'hC3, 1'b0);
        req(2'b10, 2'b00, {24'h001C02, 24'h000000});
        chk("wr_busy_rise", 32'(o_busy), 32'(2'b10));
        wait_idle("wr_idle", 200);
        chk("wr_cmd_count", 32'(cmd_cnt - c0), 32'(1));
        chk("wr_done_count", 32'(done_cnt[1] - d1), 32'(1));

        // contention and round-robin order
        m_lat = 2; m_len = 5; m_rd_val = 8'h11;
        push(0, 1'b0, 24'hA0A0A0, 8'h11, 1'b0);
        push(1, 1'b0, 24'hB1B1B1, 8'h11, 1'b0);
        req(2'b11, 2'b00, {24'hB1B1B1, 24'hA0A0A0});
        wait_idle("rr1_idle", 200);
        chk("rr1_gap", 32'(last_gap), 32'(1));
        m_rd_val = 8'h22;
        push(0, 1'b0, 24'hA2A2A2, 8'h22, 1'b0);
        push(1, 1'b0, 24'hB3B3B3, 8'h22, 1'b0);
        req(2'b11, 2'b00, {24'hB3B3B3, 24'hA2A2A2});
        wait_idle("rr2_idle", 200);
        chk("rr2_gap", 32'(last_gap), 32'(1));
        push(0, 1'b0, 24'hA4A4A4, 8'h22, 1'b0);
        req(2'b01, 2'b00, {24'h000000, 24'hA4A4A4});
        wait_idle("rr3_idle", 200);
        push(1, 1'b0, 24'hB5B5B5, 8'h22, 1'b0);
        push(0, 1'b0, 24'hA6A6A6, 8'h22, 1'b0);
        req(2'b11, 2'b00, {24'hB5B5B5, 24'hA6A6A6});
        wait_idle("rr4_idle", 200);
        chk("rr4_gap", 32'(last_gap), 32'(1));

        // read on ch0, rd wins over a simultaneous wr
        m_lat = 3; m_len = 8; m_rd_val = 8'h5A;
        c0 = cmd_cnt;
        push(0, 1'b1, 24'h800100, 8'h5A, 1'b0);
        req(2'b01, 2'b01, {24'h000000, 24'h800100});
        wait_idle("rd_idle", 200);
        chk("rd_cmd_count", 32'(cmd_cnt - c0), 32'(1));
        chk("rd_data_hold", 32'(o_rd_data), 32'(8'h5A));

        // busy never rises
        m_never = 1;
        push(0, 1'b0, 24'h123456, 8'h00, 1'b1);
        req(2'b01, 2'b00, {24'h000000, 24'h123456});
        wait_idle("to_idle", 100);
        chk("to_rd_data_hold", 32'(o_rd_data), 32'(8'h5A));
        m_never = 0; m_rd_val = 8'h3C;
        push(0, 1'b0, 24'h654321, 8'h3C, 1'b0);
        req(2'b01, 2'b00, {24'h000000, 24'h654321});
        wait_idle("post_to_idle", 200);

        // overrun: second request while busy is dropped
        m_lat = 4; m_len = 30; m_rd_val = 8'h99;
        o0 = ovr_cnt; d1 = done_cnt[1]; c0 = cmd_cnt;
        push(1, 1'b0, 24'h0A0B0C, 8'h99, 1'b0);
        req(2'b10, 2'b00, {24'h0A0B0C, 24'h000000});
        tick(2);
        req(2'b10, 2'b00, {24'hFFFFFF, 24'h000000});
        chk("ovr_err_pulse", 32'(o_err), 32'(2'b10));
        chk("ovr_busy", 32'(o_busy), 32'(2'b10));
        tick(1);
        chk("ovr_err_one_cycle", 32'(o_err), 32'(0));
        wait_idle("ovr_idle", 200);
        chk("ovr_err_count", 32'(ovr_cnt - o0), 32'(1));
        chk("ovr_done_count", 32'(done_cnt[1] - d1), 32'(1));
        chk("ovr_cmd_count", 32'(cmd_cnt - c0), 32'(1));

        // reset in WAIT_DONE
        m_lat = 2; m_len = 30; m_rd_val = 8'h77;
        d0 = done_cnt[0];
        push(0, 1'b0, 24'h777777, 8'h77, 1'b0);
        req(2'b01, 2'b00, {24'h000000, 24'h777777});
        seen = 0;
        for (int i = 0; i < 50 && !seen; i++) begin
            tick(1);
            if (spi_busy) seen = 1;
        end
        chk("mid_busy_seen", 32'(seen), 32'(1));
        tick(3);
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk_reset_vals("mid_reset");
        exp_q.delete();
        tick(3);
        rst = 1'b0;
        tick(40);
        chk("mid_reset_no_done", 32'(done_cnt[0] - d0), 32'(0));
        chk("mid_reset_idle_busy", 32'(o_busy), 32'(0));
        chk("mid_reset_idle_cs", 32'(o_cs_n), 32'(2'b11));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/spi_cfg_arbiter.md
SPI_CFG_ARBITER -- requirements
Module: spi_cfg_arbiter

Interface
REQ-001 Parameter NUM_CH, default 2: number of SPI client channels (AD9517, ADC0, ADC1, ...); range 1..8.
REQ-002 Parameter MOSI_DATA_WIDTH, default 24: width of a write word (16-bit instruction header plus data).
REQ-003 Parameter MISO_DATA_WIDTH, default 8: width of a read data word.
REQ-004 Parameter BUSY_TIMEOUT, default 255: maximum number of clk cycles to wait for spi_busy to rise after a command is issued.
REQ-005 One clock and reset: clk, rising edge; rst, asynchronous, active-high.
REQ-006 clk  in  1  system clock, shared with spi_master.
REQ-007 rst  in  1  asynchronous active-high reset.
REQ-008 i_wr_cmd  in  NUM_CH  per-channel one-cycle write request pulse.
REQ-009 i_rd_cmd  in  NUM_CH  per-channel one-cycle read request pulse.
REQ-010 i_wr_data  in  NUM_CH*MOSI_DATA_WIDTH  per-channel word; channel k occupies bits [k*MOSI_DATA_WIDTH +: MOSI_DATA_WIDTH].
REQ-011 o_busy  out  NUM_CH  per-channel busy: request pending or in flight.
REQ-012 o_done  out  NUM_CH  per-channel one-cycle completion pulse.
REQ-013 o_err  out  NUM_CH  per-channel one-cycle pulse, timeout or overrun.
REQ-014 o_rd_data  out  MISO_DATA_WIDTH  read data of the last completed transaction; valid in the o_done cycle.
REQ-015 o_spi_wr_cmd, o_spi_rd_cmd  out  1 each  one-cycle command pulses to spi_master.
REQ-016 o_spi_wr_data  out  MOSI_DATA_WIDTH  word to spi_master.
REQ-017 i_spi_busy  in  1;  i_spi_rd_data  in  MISO_DATA_WIDTH;  i_spi_ncs  in  1  (spi_master status, read data and chip select).
REQ-018 o_cs_n  out  NUM_CH  per-device chip selects.

Function
REQ-019 Each channel SHALL latch a request into a pending flag and a captured word (type = rd if i_rd_cmd, else wr); i_rd_cmd SHALL win if both pulse in the same cycle.
REQ-020 A request arriving on a channel whose o_busy is already high SHALL be dropped and SHALL pulse o_err[k] in the next cycle.
REQ-021 o_busy[k] SHALL be high from the cycle after the request until the cycle after o_done[k] or o_err[k].
REQ-022 The FSM SHALL have states IDLE, ISSUE, WAIT_BUSY, WAIT_DONE.
REQ-023 IDLE: if any channel is pending, the FSM SHALL grant using round-robin, starting the search at last_grant+1 modulo NUM_CH, then go to ISSUE.
REQ-024 ISSUE: for exactly one cycle, the FSM SHALL drive the matching o_spi_*_cmd and drive o_spi_wr_data with the captured word, then go to WAIT_BUSY.
REQ-025 WAIT_BUSY: on i_spi_busy=1 the FSM SHALL go to WAIT_DONE; if BUSY_TIMEOUT cycles elapse first, it SHALL pulse o_err[grant], clear pending and return to IDLE.
REQ-026 WAIT_DONE: on i_spi_busy falling (1 to 0), the FSM SHALL register i_spi_rd_data into o_rd_data, pulse o_done[grant] the same cycle, clear pending and return to IDLE.
REQ-027 o_spi_wr_data SHALL hold the granted word from ISSUE through WAIT_DONE.
REQ-028 o_cs_n[k] SHALL equal i_spi_ncs while the grant is k and the state is not IDLE; otherwise o_cs_n[k] SHALL be 1. Chip selects are one-hot-low and never overlap.
REQ-029 The minimum gap between the o_done pulse of one transaction and the next ISSUE SHALL be 1 cycle (one IDLE cycle).
REQ-030 o_rd_data SHALL keep its value until the next completion, and write transactions SHALL also update it.
REQ-031 With NUM_CH=1, the arbiter SHALL degenerate to a pass-through with the same FSM timing.

Reset
REQ-032 On rst high: state IDLE, all pending cleared, last_grant = NUM_CH-1 (so channel 0 is served first), timeout counter 0, o_spi_wr_cmd=o_spi_rd_cmd=0, o_spi_wr_data=0, o_rd_data=0, o_busy=o_done=o_err=0, o_cs_n all 1.
REQ-033 Reset asserted mid-transaction SHALL abort it without an o_done or o_err pulse; requests made during reset SHALL be ignored.

Verification
REQ-034 Single write: NUM_CH=2; ch1 pulses wr with 0x001C02; the spi_master model raises busy 4 cycles later for 30 cycles -> exactly one o_spi_wr_cmd with data 0x001C02, o_cs_n[1] follows i_spi_ncs, o_cs_n[0]=1 throughout, one o_done[1].
REQ-035 Contention: ch0 and ch1 pulse in the same cycle after reset -> ch0 is served first, ch1 is issued 1 cycle after o_done[0]; a repeat from both is then served ch0, ch1 (round-robin).
REQ-036 Read: ch0 pulses rd with 0x800100; the model returns 0x5A -> o_spi_rd_cmd pulses once, o_rd_data=0x5A in the o_done[0] cycle.
REQ-037 Timeout: BUSY_TIMEOUT=16; the model never raises busy -> o_err[0] pulses 16 cycles after ISSUE, o_busy[0] falls, and the next request is served normally.
REQ-038 Overrun: ch1 pulses wr twice, 3 cycles apart, while busy -> one transaction, one o_err[1], one o_done[1].
REQ-039 Reset mid-WAIT_DONE -> all outputs return to their reset values asynchronously, with no o_done pulse.
